// File: rtl/trigger_pulse_gen_pkg.sv
// trigger_pulse_gen_pkg: state encoding and small elaboration-time helpers
// shared by the trigger pulse generator files.
package trigger_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } trigState_t;

  // Larger of two tick counts; sizes the shared phase tick counter.
  function automatic int maxTicks(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trigger_pulse_gen_if.sv
// trigger_pulse_gen_if: start/abort requests from the controller and the
// trigger/busy/done status returned to it.
interface trigger_pulse_gen_if;

  logic i_start;
  logic i_abort;
  logic o_trig;
  logic o_busy;
  logic o_done;

  // Controller side: issues requests, watches status.
  modport master (
    output i_start,
    output i_abort,
    input  o_trig,
    input  o_busy,
    input  o_done
  );

  // Pulse generator side: takes requests, drives status.
  modport slave (
    input  i_start,
    input  i_abort,
    output o_trig,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/trigger_pulse_gen_tick_gen.sv
// trig_tick_gen: free-running prescaler producing a one-cycle tick every
// TICK_DIV clocks. A synchronous clear restarts the count so that a new
// phase always starts with a full tick period.
module trig_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next count: wrap after the last count, restart on clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/trigger_pulse_gen.sv
// trigger_pulse_gen: turns a one-cycle start strobe into a trigger pulse of
// PULSE_TICKS ticks followed by a HOLDOFF_TICKS lockout, then strobes done.
// Starts while busy are dropped; abort cuts the pulse short but keeps the
// full lockout.
module trigger_pulse_gen
  import trigger_pulse_gen_pkg::*;
#(
  parameter int TICK_DIV      = 100,
  parameter int PULSE_TICKS   = 10,
  parameter int HOLDOFF_TICKS = 60000
) (
  input logic              clk,
  input logic              rst,
  trigger_pulse_gen_if.slave bus
);

  localparam int CW = $clog2(maxTicks(PULSE_TICKS, HOLDOFF_TICKS) + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_TICKS - 1);

  trigState_t    state_q;
  logic [CW-1:0] tickCnt_q;
  logic          trig_q;
  logic          busy_q;
  logic          done_q;

  logic          tick;
  logic          tickClear;
  logic          startAccept;
  logic          pulseEnd;

  assign startAccept = (state_q == IDLE) && bus.i_start;
  assign pulseEnd    = (state_q == PULSE) &&
                       (bus.i_abort || (tick && (tickCnt_q == PULSE_LAST)));
  assign tickClear   = startAccept || pulseEnd;

  trig_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tickClear),
    .tick_o  (tick)
  );

  // Phase FSM with tick counter and registered trig/busy/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            state_q   <= PULSE;
            tickCnt_q <= '0;
            trig_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        PULSE: begin
          if (pulseEnd) begin
            state_q   <= HOLD;
            tickCnt_q <= '0;
            trig_q    <= 1'b0;
          end else if (tick) begin
            tickCnt_q <= tickCnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (tick && (tickCnt_q == HOLD_LAST)) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (tick) begin
            tickCnt_q <= tickCnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          tickCnt_q <= '0;
          trig_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_trig = trig_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// tb_trigger_pulse_gen: directed vector table for the trigger pulse generator
// with TICK_DIV=4, PULSE_TICKS=3, HOLDOFF_TICKS=5 (12-cycle pulse, 32-cycle
// busy window, done in cycle 32), plus hand-written reset sequences.
module tb_trigger_pulse_gen;

  localparam int TICK_DIV      = 4;
  localparam int PULSE_TICKS   = 3;
  localparam int HOLDOFF_TICKS = 5;

  // One vector: inputs sampled at edge e, expected {trig,busy,done} in cycle e.
  typedef struct {
    logic       start;
    logic       abort;
    logic [2:0] exp;
    int         tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  trigger_pulse_gen_if bus();

  trigger_pulse_gen #(
    .TICK_DIV      (TICK_DIV),
    .PULSE_TICKS   (PULSE_TICKS),
    .HOLDOFF_TICKS (HOLDOFF_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   s2First;
  int   s2Last;

  // Append one vector to the table.
  task automatic addVec(input logic s, input logic a, input logic t,
                        input logic b, input logic d, input int tag);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.exp   = {t, b, d};
    v.tag   = tag;
    vecs.push_back(v);
  endtask

  // Append n quiet idle vectors.
  task automatic addIdle(input int n, input int tag);
    for (int i = 0; i < n; i++) addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Compare current outputs against the expected triple.
  task automatic checkOutput(input int tag, input int idx, input logic [2:0] exp);
    logic [2:0] act;
    act = {bus.o_trig, bus.o_busy, bus.o_done};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL scen%0d step %0d trig/busy/done got=%b want=%b",
               tag, idx, act, exp);
    end
  endtask

  // Apply vectors first..last: drive at negedge, sample the next negedge.
  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.i_start = vecs[i].start;
      bus.i_abort = vecs[i].abort;
      @(posedge clk);
      @(negedge clk);
      checkOutput(vecs[i].tag, i, vecs[i].exp);
    end
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;

    // Scenario 1: asynchronous reset mid-cycle clears everything at once.
    #3 rst = 1'b1;
    #1 checkOutput(1, -1, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Build the vector table.
    addIdle(3, 1);

    // Scenario 2: single start accepted at edge 0.
    s2First = vecs.size();
    for (int e = 0; e <= 33; e++)
      addVec(e == 0, 1'b0, e < 12, e < 32, e == 32, 2);
    s2Last = vecs.size() - 1;
    addIdle(2, 2);

    // Scenario 3: starts during PULSE and HOLD are ignored.
    for (int e = 0; e <= 33; e++)
      addVec((e == 0) || (e == 6) || (e == 21) || (e >= 23 && e <= 29),
             1'b0, e < 12, e < 32, e == 32, 3);
    addIdle(2, 3);

    // Scenario 4: start during the done cycle, second run back-to-back.
    for (int e = 0; e <= 66; e++)
      addVec((e == 0) || (e == 33), 1'b0,
             (e < 12) || (e >= 33 && e < 45),
             (e < 32) || (e >= 33 && e < 65),
             (e == 32) || (e == 65), 4);
    addIdle(2, 4);

    // Scenario 5: start+abort together (start wins), abort in cycle 5,
    // abort again in HOLD (ignored), then abort alone in IDLE (ignored).
    for (int e = 0; e <= 27; e++)
      addVec(e == 0, (e == 0) || (e == 6) || (e == 20),
             e < 6, e < 26, e == 26, 5);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    addIdle(2, 5);

    applyStimulus(0, vecs.size() - 1);

    // Scenario 6: reset in cycle 4 of a pulse, then a clean rerun.
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 checkOutput(6, 4, 3'b110);
    rst = 1'b1;
    #1 checkOutput(6, 4, 3'b000);
    @(posedge clk);
    @(negedge clk);
    checkOutput(6, 5, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput(6, 6, 3'b000);
    applyStimulus(s2First, s2Last);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
